// File: rtl/mvm_pkg.sv
// mvm_pkg
// Shared constants and types for the matrix-vector multiplier datapath and
// its result write-back master.
//   rw_state_t    : write-back FSM states (encodings are visible on LEDs)
//   RESULT_W      : width of one accumulator result
//   BUS_W         : Avalon-MM data bus width
//   MVM_NUM_OUT   : number of accumulator results per matrix-vector product
//   zext_result() : zero-extends a result onto the data bus
package mvm_pkg;

    localparam int unsigned RESULT_W    = 24;
    localparam int unsigned BUS_W       = 64;
    localparam int unsigned MVM_NUM_OUT = 8;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'd0,
        RW_WRITE = 2'd1,
        RW_DONE  = 2'd2,
        RW_ERROR = 2'd3
    } rw_state_t;

    function automatic logic [BUS_W-1:0] zext_result(input logic [RESULT_W-1:0] r);
        return {{(BUS_W - RESULT_W){1'b0}}, r};
    endfunction

endpackage

// File: rtl/result_writeback.sv
// result_writeback
// Avalon-MM write master that snapshots the eight accumulator results of
// mat_vec_mult on `start` and writes them, one 64-bit word each, to
// BASE_ADDR + index*STRIDE. A write that stalls TIMEOUT consecutive cycles
// aborts the sequence into ERROR.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle request (ignored while writing)
//   mac_out_0..7        : accumulator results to be written
//   avm_address/write/writedata, avm_waitrequest : Avalon-MM write master
//   busy, done, error   : status levels decoded from the FSM state
//   state_out           : raw FSM encoding for LEDs
//   wr_count            : number of writes accepted in the current run
module result_writeback
    import mvm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int unsigned STRIDE    = 8,
    parameter int unsigned NUM_OUT   = MVM_NUM_OUT,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RESULT_W-1:0] mac_out_0,
    input  logic [RESULT_W-1:0] mac_out_1,
    input  logic [RESULT_W-1:0] mac_out_2,
    input  logic [RESULT_W-1:0] mac_out_3,
    input  logic [RESULT_W-1:0] mac_out_4,
    input  logic [RESULT_W-1:0] mac_out_5,
    input  logic [RESULT_W-1:0] mac_out_6,
    input  logic [RESULT_W-1:0] mac_out_7,
    output logic [31:0]         avm_address,
    output logic                avm_write,
    output logic [BUS_W-1:0]    avm_writedata,
    input  logic                avm_waitrequest,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          state_out,
    output logic [3:0]          wr_count
);

    localparam int unsigned          STALL_W    = $clog2(TIMEOUT);
    localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [STALL_W-1:0]   STALL_ONE  = STALL_W'(1);
    localparam logic [2:0]           LAST_IDX   = 3'(NUM_OUT - 1);
    localparam logic [31:0]          STRIDE_B   = 32'(STRIDE);

    rw_state_t           state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [31:0]         addr_q, addr_d;
    logic [BUS_W-1:0]    data_q, data_d;
    logic [RESULT_W-1:0] snap_q [8];
    logic [RESULT_W-1:0] snap_d [8];
    logic [RESULT_W-1:0] mac_in [8];

    always_comb begin
        mac_in[0] = mac_out_0;
        mac_in[1] = mac_out_1;
        mac_in[2] = mac_out_2;
        mac_in[3] = mac_out_3;
        mac_in[4] = mac_out_4;
        mac_in[5] = mac_out_5;
        mac_in[6] = mac_out_6;
        mac_in[7] = mac_out_7;
    end

    // Address and data are registered and only advance on acceptance, so
    // they are inherently held stable while the slave asserts waitrequest.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        addr_d  = addr_q;
        data_d  = data_q;
        snap_d  = snap_q;

        case (state_q)
            RW_WRITE: begin
                if (!avm_waitrequest) begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = cnt_q + 4'd1;
                    stall_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = RW_DONE;
                    end else begin
                        addr_d = addr_q + STRIDE_B;
                        data_d = zext_result(snap_q[idx_d]);
                    end
                end else begin
                    stall_d = stall_q + STALL_ONE;
                    // stall_q still holds the count of earlier stalls, so this
                    // is the TIMEOUT-th consecutive stalled cycle.
                    if (stall_q == STALL_LAST) begin
                        state_d = RW_ERROR;
                    end
                end
            end
            default: begin
                // IDLE, DONE, ERROR: a start restarts from scratch. The first
                // word comes straight from the inputs since the snapshot is
                // being captured on this same edge.
                if (start) begin
                    snap_d  = mac_in;
                    idx_d   = '0;
                    cnt_d   = '0;
                    stall_d = '0;
                    addr_d  = BASE_ADDR;
                    data_d  = zext_result(mac_in[0]);
                    state_d = RW_WRITE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RW_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            // NOTE: the snapshot array is small and must read as zero after
            // reset, so it is reset along with the control flops.
            snap_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            snap_q  <= snap_d;
        end
    end

    assign avm_write     = (state_q == RW_WRITE);
    assign avm_address   = addr_q;
    assign avm_writedata = data_q;
    assign busy          = (state_q == RW_WRITE);
    assign done          = (state_q == RW_DONE);
    assign error         = (state_q == RW_ERROR);
    assign state_out     = state_q;
    assign wr_count      = cnt_q;

endmodule
